// File: rtl/button_sync.sv
// ============================================================================
//  Module   : button_sync
//  Brief    : Two independent pushbutton channels (Run, Continue), each with
//             a 2-flop synchronizer, debounce counter and press pulse.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module button_sync #(
    parameter int DB_CYCLES = 1,
    parameter int CNT_W     = 20
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic Continue,
    output logic Run_pulse,
    output logic Continue_pulse,
    output logic Run_held,
    output logic Continue_held
);

    // One bit wider than the counter so cnt+1 can reach DB_CYCLES without wrap.
    localparam logic [CNT_W:0] c_DB_LIM = (CNT_W + 1)'(DB_CYCLES);

    logic [1:0] w_raw;
    logic [1:0] w_pulse;
    logic [1:0] w_held;

    assign w_raw = {Continue, Run};

    generate
        for (genvar i = 0; i < 2; i++) begin : g_ch
            logic             s1_q;
            logic             s2_q;
            logic             db_q;
            logic             db_d;
            logic             pulse_q;
            logic             held_q;
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            always_comb begin
                db_d  = db_q;
                cnt_d = cnt_q;
                if (s2_q == db_q) begin
                    cnt_d = '0;
                end else if (({1'b0, cnt_q} + 1'b1) == c_DB_LIM) begin
                    db_d  = s2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    s1_q    <= 1'b1;
                    s2_q    <= 1'b1;
                    db_q    <= 1'b1;
                    cnt_q   <= '0;
                    pulse_q <= 1'b0;
                    held_q  <= 1'b0;
                end else begin
                    s1_q    <= w_raw[i];
                    s2_q    <= s1_q;
                    db_q    <= db_d;
                    cnt_q   <= cnt_d;
                    // Press only: debounced level falling from released to pressed.
                    pulse_q <= db_q & ~db_d;
                    held_q  <= ~db_d;
                end
            end

            assign w_pulse[i] = pulse_q;
            assign w_held[i]  = held_q;
        end
    endgenerate

    assign Run_pulse      = w_pulse[0];
    assign Continue_pulse = w_pulse[1];
    assign Run_held       = w_held[0];
    assign Continue_held  = w_held[1];

endmodule

`default_nettype wire

// File: tb/tb_button_sync.sv
// ============================================================================
//  Module   : tb_button_sync
//  Brief    : Randomized and directed bench for button_sync at DB_CYCLES 1 and 3
//             against a run-length reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_button_sync;

    localparam int c_MAXC = 4096;

    logic clk = 1'b0;
    logic rst;
    logic run_n;
    logic cont_n;

    logic [3:0] w_out [2];

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;
    int last_rst = -100;

    bit hist [2][c_MAXC];
    int m_run   [2][2];
    bit m_db    [2][2];
    bit m_pulse [2][2];
    bit m_held  [2][2];

    always #5 clk = ~clk;

    button_sync #(.DB_CYCLES(1), .CNT_W(20)) u_db1 (
        .Clk            (clk),
        .Reset          (rst),
        .Run            (run_n),
        .Continue       (cont_n),
        .Run_pulse      (w_out[0][0]),
        .Continue_pulse (w_out[0][1]),
        .Run_held       (w_out[0][2]),
        .Continue_held  (w_out[0][3])
    );

    button_sync #(.DB_CYCLES(3), .CNT_W(4)) u_db3 (
        .Clk            (clk),
        .Reset          (rst),
        .Run            (run_n),
        .Continue       (cont_n),
        .Run_pulse      (w_out[1][0]),
        .Continue_pulse (w_out[1][1]),
        .Run_held       (w_out[1][2]),
        .Continue_held  (w_out[1][3])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0b expected %0b", tag, k, obs, exp);
    endtask

    // Synchronized value seen by the debouncer at edge e: raw from two edges
    // earlier, or released if that sample predates the end of reset.
    function automatic bit sync_at(input int ch, input int e);
        if (e - 2 > last_rst) return hist[ch][e - 2];
        return 1'b1;
    endfunction

    task automatic model_edge(input bit r, input bit rn, input bit cn);
        int db_len;
        bit s;
        hist[0][k] = rn;
        hist[1][k] = cn;
        for (int i = 0; i < 2; i++) begin
            db_len = (i == 0) ? 1 : 3;
            for (int c = 0; c < 2; c++) begin
                m_pulse[i][c] = 1'b0;
                if (r) begin
                    m_db[i][c]   = 1'b1;
                    m_run[i][c]  = 0;
                    m_held[i][c] = 1'b0;
                end else begin
                    s = sync_at(c, k);
                    if (s == m_db[i][c]) begin
                        m_run[i][c] = 0;
                    end else begin
                        m_run[i][c]++;
                        if (m_run[i][c] == db_len) begin
                            m_db[i][c]    = s;
                            m_run[i][c]   = 0;
                            m_pulse[i][c] = (s == 1'b0);
                        end
                    end
                    m_held[i][c] = ~m_db[i][c];
                end
            end
        end
        if (r) last_rst = k;
    endtask

    task automatic step(input bit r, input bit rn, input bit cn);
        string nm [4];
        bit    ex [4];
        nm = '{"run_pulse", "cont_pulse", "run_held", "cont_held"};
        @(negedge clk);
        rst    = r;
        run_n  = rn;
        cont_n = cn;
        @(posedge clk);
        model_edge(r, rn, cn);
        #1;
        for (int i = 0; i < 2; i++) begin
            ex = '{m_pulse[i][0], m_pulse[i][1], m_held[i][0], m_held[i][1]};
            for (int b = 0; b < 4; b++)
                chk($sformatf("db%0d.%s", (i == 0) ? 1 : 3, nm[b]), w_out[i][b], ex[b]);
        end
        k++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int len;
        bit rv, cv;
        rst    = 1'b1;
        run_n  = 1'b1;
        cont_n = 1'b1;

        // Reset state, then a one-cycle Run glitch.
        for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 1'b1);
        idle(7);
        step(1'b0, 1'b0, 1'b1);
        idle(9);

        // Short Continue blip, then a long hold.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(8);
        for (int j = 0; j < 12; j++) step(1'b0, 1'b1, 1'b0);
        idle(10);

        // Run chatter followed by a steady press.
        for (int j = 0; j < 10; j++) step(1'b0, j[0], 1'b1);
        for (int j = 0; j < 10; j++) step(1'b0, 1'b0, 1'b1);
        idle(10);

        // Simultaneous presses.
        for (int j = 0; j < 8; j++) step(1'b0, 1'b0, 1'b0);
        idle(10);

        // Run held low across a reset.
        for (int j = 0; j < 5; j++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) step(1'b0, 1'b0, 1'b1);
        idle(10);

        // Randomized segments with bounce and occasional reset.
        rv = 1'b1;
        cv = 1'b1;
        while (k < c_MAXC - 20) begin
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 3) == 0) rv = ~rv;
            if ($urandom_range(0, 3) == 0) cv = ~cv;
            for (int j = 0; j < len && k < c_MAXC - 20; j++) begin
                step(($urandom_range(0, 99) == 0),
                     ($urandom_range(0, 9) == 0) ? ~rv : rv,
                     ($urandom_range(0, 9) == 0) ? ~cv : cv);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
